// File: rtl/div_nonrestoring.sv
// div_nonrestoring
//   Sequential unsigned divider using the non-restoring algorithm. Each RUN
//   cycle retires one quotient bit. A final FIX cycle corrects a negative
//   partial remainder. A zero divisor takes a single-cycle DZ path instead of
//   running any iterations.
//
// Ports
//   clk          single clock; all state changes on the rising edge
//   rst          synchronous, active-high reset
//   start        request a division; sampled only in IDLE
//   dividend     unsigned dividend, sampled with start
//   divisor      unsigned divisor, sampled with start
//   busy         high in RUN, FIX and DZ; low in IDLE, including the done cycle
//   done         one-cycle pulse; quotient/remainder/div_by_zero are valid
//   quotient     registered quotient (all ones on divide by zero)
//   remainder    registered remainder (the sampled dividend on divide by zero)
//   div_by_zero  registered flag, updated with done
module div_nonrestoring #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_DZ
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [WIDTH:0]   r_a;     // signed partial remainder, WIDTH+1 bits
  logic [WIDTH-1:0] r_q;     // dividend shifting out / quotient shifting in
  logic [WIDTH:0]   r_m;     // zero-extended divisor
  logic [CW-1:0]    r_cnt;
  logic             r_done;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_dz;

  logic [WIDTH:0]   w_sh_a;
  logic [WIDTH:0]   w_addsub;
  logic [WIDTH-1:0] w_q_next;
  logic [WIDTH:0]   w_a_fix;
  logic             w_last_iter;

  // One non-restoring step: the sign of A before the shift selects add or
  // subtract; the new sign decides the quotient bit. Carry out is dropped.
  always_comb begin
    w_sh_a   = {r_a[WIDTH-1:0], r_q[WIDTH-1]};
    w_addsub = r_a[WIDTH] ? (w_sh_a + r_m) : (w_sh_a - r_m);
    w_q_next = {r_q[WIDTH-2:0], ~w_addsub[WIDTH]};
    w_a_fix  = r_a[WIDTH] ? (r_a + r_m) : r_a;
  end

  assign w_last_iter = (r_cnt == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = (divisor == '0) ? S_DZ : S_RUN;
        end
      end
      S_RUN: begin
        if (w_last_iter) begin
          w_state_next = S_FIX;
        end
      end
      S_FIX:   w_state_next = S_IDLE;
      S_DZ:    w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (r_state != S_IDLE);
  end

  // Datapath and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_q    <= '0;
      r_m    <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
      r_quot <= '0;
      r_rem  <= '0;
      r_dz   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Q also carries the dividend to DZ, where it becomes the remainder.
          if (start) begin
            r_a   <= '0;
            r_q   <= dividend;
            r_m   <= {1'b0, divisor};
            r_cnt <= '0;
          end
        end
        S_RUN: begin
          r_a   <= w_addsub;
          r_q   <= w_q_next;
          r_cnt <= r_cnt + CW'(1);
        end
        S_FIX: begin
          r_a    <= w_a_fix;
          r_quot <= r_q;
          r_rem  <= w_a_fix[WIDTH-1:0];
          r_dz   <= 1'b0;
          r_done <= 1'b1;
        end
        S_DZ: begin
          r_quot <= '1;
          r_rem  <= r_q;
          r_dz   <= 1'b1;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign done        = r_done;
  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign div_by_zero = r_dz;

endmodule

// File: tb/tb_div_nonrestoring.sv
module tb_div_nonrestoring;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int n_tests = 0;
  int n_fail  = 0;

  div_nonrestoring #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Issue one start pulse and measure cycles from the sampling edge to the
  // cycle in which done is seen (sampled on falling edges). Gives up at 30.
  task automatic run_div(input logic [7:0] a, input logic [7:0] b, output int lat);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat   = 0;
    while (!done && lat < 30) begin
      @(negedge clk);
      lat++;
    end
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    int         lat;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int lat;
    int ndone;
    int exp_q;
    int exp_r;

    vecs[0] = '{a: 8'd100, b: 8'd7,   q: 8'd14,  r: 8'd2, dz: 1'b0, lat: 9};
    vecs[1] = '{a: 8'd255, b: 8'd1,   q: 8'd255, r: 8'd0, dz: 1'b0, lat: 9};
    vecs[2] = '{a: 8'd3,   b: 8'd10,  q: 8'd0,   r: 8'd3, dz: 1'b0, lat: 9};
    vecs[3] = '{a: 8'd200, b: 8'd200, q: 8'd1,   r: 8'd0, dz: 1'b0, lat: 9};
    vecs[4] = '{a: 8'd5,   b: 8'd0,   q: 8'd255, r: 8'd5, dz: 1'b1, lat: 1};
    vecs[5] = '{a: 8'd255, b: 8'd128, q: 8'd1,   r: 8'd127, dz: 1'b0, lat: 9};

    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_q", quotient, 0);
    check("reset_r", remainder, 0);
    check("reset_dz", div_by_zero, 0);
    rst = 1'b0;

    // Directed vectors
    foreach (vecs[i]) begin
      run_div(vecs[i].a, vecs[i].b, lat);
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d_q", i), quotient, vecs[i].q);
      check($sformatf("v%0d_r", i), remainder, vecs[i].r);
      check($sformatf("v%0d_dz", i), div_by_zero, vecs[i].dz);
      check($sformatf("v%0d_busy_in_done", i), busy, 0);
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", i), done, 0);
    end

    // Results hold until the next completion
    repeat (5) @(negedge clk);
    check("hold_q", quotient, 1);
    check("hold_r", remainder, 127);

    // Start during RUN is ignored
    @(negedge clk);
    dividend = 8'd100; divisor = 8'd7; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    dividend = 8'd9; divisor = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int c = 0; c < 16; c++) begin
      if (done) begin
        ndone++;
        check("ign_q", quotient, 14);
        check("ign_r", remainder, 2);
      end
      @(negedge clk);
    end
    check("ign_done_count", ndone, 1);

    // Reset mid-division aborts with no done pulse
    @(negedge clk);
    dividend = 8'd100; divisor = 8'd7; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_q", quotient, 0);
    check("abort_r", remainder, 0);
    check("abort_dz", div_by_zero, 0);
    ndone = 0;
    for (int c = 0; c < 14; c++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check("abort_no_done", ndone, 0);
    run_div(8'd50, 8'd6, lat);
    check("after_abort_latency", lat, 9);
    check("after_abort_q", quotient, 8);
    check("after_abort_r", remainder, 2);

    // start held high: back-to-back operations, each with its own operands
    @(negedge clk);
    dividend = 8'd100; divisor = 8'd7; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    lat = 0;
    while (!done && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    check("b2b_first_latency", lat, 9);
    check("b2b_first_q", quotient, 14);
    dividend = 8'd77; divisor = 8'd0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    check("b2b_second_latency", lat, 1);
    check("b2b_second_q", quotient, 255);
    check("b2b_second_r", remainder, 77);
    check("b2b_second_dz", div_by_zero, 1);

    // Operand grid sweep against integer division
    for (int a = 0; a < 256; a += 17) begin
      for (int b = 0; b < 256; b += 23) begin
        run_div(a[7:0], b[7:0], lat);
        if (b == 0) begin
          exp_q = 255;
          exp_r = a;
        end else begin
          exp_q = a / b;
          exp_r = a % b;
        end
        check($sformatf("sweep_%0d_%0d_lat", a, b), lat, (b == 0) ? 1 : 9);
        check($sformatf("sweep_%0d_%0d_q", a, b), quotient, exp_q);
        check($sformatf("sweep_%0d_%0d_r", a, b), remainder, exp_r);
        check($sformatf("sweep_%0d_%0d_dz", a, b), div_by_zero, (b == 0) ? 1 : 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
